vga_bus_arbiter: RTL and testbench



---
 rtl/vga_bus_arbiter_if.sv | 43 ++++
 rtl/vga_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vga_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_bus_arbiter_if.sv
// VGA-side bus arbiter interface.
// Groups the requester handshake (req/fields/ack/rdata) with the VGA ISA-style bus pins.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the VGA pad model.
interface vga_bus_arbiter_if #(
  parameter int DATA_W = 16
);
  // Requester side
  logic [1:0]        req;
  logic [1:0]        io;
  logic [1:0]        rw;
  logic [1:0]        sa0;
  logic [1:0]        sa12;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              timeout;
  logic              busy;
  // VGA bus side
  logic              BALE;
  logic              IOR;
  logic              IOW;
  logic              MEMR;
  logic              MEMW;
  logic              SA0;
  logic              SA12;
  logic [DATA_W-1:0] DG_OUT;
  logic              DG_OE;
  logic [DATA_W-1:0] DG_IN;
  logic              WAIT;

  modport slave (
    input  req, io, rw, sa0, sa12, wdata0, wdata1, DG_IN, WAIT,
    output ack, rdata, timeout, busy,
    output BALE, IOR, IOW, MEMR, MEMW, SA0, SA12, DG_OUT, DG_OE
  );

  modport master (
    output req, io, rw, sa0, sa12, wdata0, wdata1, DG_IN, WAIT,
    input  ack, rdata, timeout, busy,
    input  BALE, IOR, IOW, MEMR, MEMW, SA0, SA12, DG_OUT, DG_OE
  );
endinterface

// File: rtl/vga_bus_arbiter.sv
// VGA bus arbiter.
// It round-robins between the Zorro slave decoder (requester 0) and the register-init/blit engine (requester 1).
// It runs one timed ISA-style cycle per grant, with WAIT stretching and a timeout.
// All bus pins come straight from flops, so the pad timing does not depend on the decode logic.
module vga_bus_arbiter #(
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_STROBE     = 3,
  parameter int unsigned T_HOLD       = 1,
  parameter int unsigned T_RECOVER    = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic             mclk,
  input  logic             reset,
  vga_bus_arbiter_if.slave bus
);

  localparam int DATA_W = 16;

  // Phase lengths as last-count values for the 3-bit phase counter
  localparam logic [2:0] SETUP_LAST   = 3'(T_SETUP - 1);
  localparam logic [2:0] STROBE_LAST  = 3'(T_STROBE - 1);
  localparam logic [2:0] HOLD_LAST    = 3'(T_HOLD - 1);
  localparam logic [2:0] RECOVER_LAST = 3'(T_RECOVER - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(WAIT_TIMEOUT);

  // Strobe vector order {MEMW, MEMR, IOW, IOR}; all active-low
  localparam logic [3:0] STRB_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_STROBE,
    ST_STRETCH,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  // Saturating increments: counters stick at all-ones instead of wrapping
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'h7) ? v : v + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Exactly one strobe low, chosen by space and direction
  function automatic logic [3:0] strobe_sel(input logic io_v, input logic rw_v);
    logic [3:0] s;
    case ({io_v, rw_v})
      2'b11:   s = 4'b1110;  // IOR
      2'b10:   s = 4'b1101;  // IOW
      2'b01:   s = 4'b1011;  // MEMR
      default: s = 4'b0111;  // MEMW
    endcase
    return s;
  endfunction

  // Control and bus-pin state
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        stretch_q, stretch_d;
  logic              pend_q, pend_d;
  logic              bale_q, bale_d;
  logic [3:0]        strb_q, strb_d;
  logic              sa0_q, sa0_d;
  logic              sa12_q, sa12_d;
  logic [DATA_W-1:0] dg_out_q, dg_out_d;
  logic              dg_oe_q, dg_oe_d;
  logic [1:0]        ack_q, ack_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;

  // Latched request attributes (no reset needed: written in LATCH before any use)
  logic              io_lat_q, io_lat_d;
  logic              rw_lat_q, rw_lat_d;

  // Strobe-release request shared by the STROBE and STRETCH exits
  logic              to_hold;
  logic              tmo_now;

  // Next-state and next-output decode for the whole bus cycle
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    phase_d      = phase_q;
    stretch_d    = stretch_q;
    pend_d       = pend_q;
    bale_d       = bale_q;
    strb_d       = strb_q;
    sa0_d        = sa0_q;
    sa12_d       = sa12_q;
    dg_out_d     = dg_out_q;
    dg_oe_d      = dg_oe_q;
    ack_d        = 2'b00;
    tmo_d        = 1'b0;
    rdata_d      = rdata_q;
    io_lat_d     = io_lat_q;
    rw_lat_d     = rw_lat_q;
    to_hold      = 1'b0;
    tmo_now      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          // On contention the requester that did not win last time goes first
          grant_d = (bus.req == 2'b11) ? ~last_grant_q : bus.req[1];
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        io_lat_d     = bus.io[grant_q];
        rw_lat_d     = bus.rw[grant_q];
        sa0_d        = bus.sa0[grant_q];
        sa12_d       = bus.sa12[grant_q];
        bale_d       = 1'b0;
        last_grant_d = grant_q;
        if (!bus.rw[grant_q]) begin
          dg_out_d = grant_q ? bus.wdata1 : bus.wdata0;
          dg_oe_d  = 1'b1;
        end
        phase_d = 3'd0;
        state_d = ST_SETUP;
      end

      ST_SETUP: begin
        if (phase_q >= SETUP_LAST) begin
          phase_d = 3'd0;
          strb_d  = strobe_sel(io_lat_q, rw_lat_q);
          state_d = ST_STROBE;
        end else begin
          phase_d = sat_inc3(phase_q);
        end
      end

      ST_STROBE: begin
        if (phase_q >= STROBE_LAST) begin
          // Only memory cycles honour WAIT; IO cycles release on time
          if (!io_lat_q && !bus.WAIT) begin
            stretch_d = 8'd0;
            state_d   = ST_STRETCH;
          end else begin
            to_hold = 1'b1;
          end
        end else begin
          phase_d = sat_inc3(phase_q);
        end
      end

      ST_STRETCH: begin
        if (bus.WAIT) begin
          to_hold = 1'b1;
        end else begin
          stretch_d = sat_inc8(stretch_q);
          if (sat_inc8(stretch_q) >= WAIT_LIMIT) begin
            to_hold = 1'b1;
            tmo_now = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (phase_q >= HOLD_LAST) begin
          bale_d   = 1'b1;
          sa0_d    = 1'b1;
          sa12_d   = 1'b1;
          dg_oe_d  = 1'b0;
          dg_out_d = '0;
          ack_d    = grant_q ? 2'b10 : 2'b01;
          tmo_d    = pend_q;
          pend_d   = 1'b0;
          phase_d  = 3'd0;
          state_d  = ST_RECOVER;
        end else begin
          phase_d = sat_inc3(phase_q);
        end
      end

      ST_RECOVER: begin
        if (phase_q >= RECOVER_LAST) begin
          phase_d = 3'd0;
          state_d = ST_IDLE;
        end else begin
          phase_d = sat_inc3(phase_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Strobe release edge: read data is captured on the same edge the strobe rises
    if (to_hold) begin
      strb_d  = STRB_IDLE;
      phase_d = 3'd0;
      state_d = ST_HOLD;
      if (tmo_now) begin
        pend_d = 1'b1;
      end
      if (rw_lat_q) begin
        rdata_d = (pend_q || tmo_now) ? 16'hFFFF : bus.DG_IN;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control and pin flops; async reset drops every strobe at once
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      phase_q      <= 3'd0;
      stretch_q    <= 8'd0;
      pend_q       <= 1'b0;
      bale_q       <= 1'b1;
      strb_q       <= STRB_IDLE;
      sa0_q        <= 1'b1;
      sa12_q       <= 1'b1;
      dg_out_q     <= '0;
      dg_oe_q      <= 1'b0;
      ack_q        <= 2'b00;
      tmo_q        <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      phase_q      <= phase_d;
      stretch_q    <= stretch_d;
      pend_q       <= pend_d;
      bale_q       <= bale_d;
      strb_q       <= strb_d;
      sa0_q        <= sa0_d;
      sa12_q       <= sa12_d;
      dg_out_q     <= dg_out_d;
      dg_oe_q      <= dg_oe_d;
      ack_q        <= ack_d;
      tmo_q        <= tmo_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Latched request attributes
  always_ff @(posedge mclk) begin
    io_lat_q <= io_lat_d;
    rw_lat_q <= rw_lat_d;
  end

  assign bus.BALE    = bale_q;
  assign bus.IOR     = strb_q[0];
  assign bus.IOW     = strb_q[1];
  assign bus.MEMR    = strb_q[2];
  assign bus.MEMW    = strb_q[3];
  assign bus.SA0     = sa0_q;
  assign bus.SA12    = sa12_q;
  assign bus.DG_OUT  = dg_out_q;
  assign bus.DG_OE   = dg_oe_q;
  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.timeout = tmo_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Testbench for vga_bus_arbiter.
// It has scoreboarded requester transactions, a WAIT pad model and bus-pin timing monitors.
module tb_vga_bus_arbiter;

  localparam int T_STROBE_TB = 3;

  logic mclk = 1'b0;
  logic reset;

  always #10 mclk = ~mclk;

  vga_bus_arbiter_if bus ();

  vga_bus_arbiter #(
    .T_SETUP(2), .T_STROBE(T_STROBE_TB), .T_HOLD(1), .T_RECOVER(2), .WAIT_TIMEOUT(8)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        chk_rd;
    logic        tmo;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        tmo;
    int          cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_a[64];

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int ack_cnt = 0;
  int cyc = 0;
  int stretch_n = 0;

  // Monitor state (written only by the monitor)
  int         mcnt = 0;
  int         strb_cnt = 0;
  int         strb_id = 0;
  int         last_strb_len = 0;
  int         last_strb_id = -1;
  int         bale_cnt = 0;
  int         last_bale_len = 0;
  logic [1:0] rec_sa = 2'b00;
  int         oe_cnt = 0;
  int         last_oe_len = 0;
  logic [15:0] rec_dg_out = 16'h0;
  logic       multi_seen = 1'b0;
  logic       ack_prev = 1'b0;
  logic       tmo_next = 1'b0;
  logic [1:0] ack_next = 2'b00;

  wire [3:0] lows_w = ~{bus.MEMW, bus.MEMR, bus.IOW, bus.IOR};

  function automatic int low_id(input logic [3:0] l);
    if (l[0]) return 0;
    if (l[1]) return 1;
    if (l[2]) return 2;
    return 3;
  endfunction

  always @(posedge mclk) cyc <= cyc + 1;

  // Pin monitor and WAIT pad model, sampled on the falling edge
  always @(negedge mclk) begin
    if ($countones(lows_w) > 1) multi_seen <= 1'b1;

    if (lows_w != 4'b0000) begin
      strb_cnt <= strb_cnt + 1;
      strb_id  <= low_id(lows_w);
    end else if (strb_cnt != 0) begin
      last_strb_len <= strb_cnt;
      last_strb_id  <= strb_id;
      strb_cnt      <= 0;
    end

    if (lows_w[3] || lows_w[2]) begin
      mcnt     <= mcnt + 1;
      bus.WAIT <= ((mcnt + 1) >= (T_STROBE_TB + stretch_n));
    end else begin
      mcnt     <= 0;
      bus.WAIT <= 1'b1;
    end

    if (!bus.BALE) begin
      bale_cnt <= bale_cnt + 1;
      if (bale_cnt == 0) rec_sa <= {bus.SA12, bus.SA0};
    end else if (bale_cnt != 0) begin
      last_bale_len <= bale_cnt;
      bale_cnt      <= 0;
    end

    if (bus.DG_OE) begin
      oe_cnt     <= oe_cnt + 1;
      rec_dg_out <= bus.DG_OUT;
    end else if (oe_cnt != 0) begin
      last_oe_len <= oe_cnt;
      oe_cnt      <= 0;
    end

    if (ack_prev) begin
      tmo_next <= bus.timeout;
      ack_next <= bus.ack;
    end
    ack_prev <= |bus.ack;
    if (bus.ack != 2'b00 && ack_cnt < 64) begin
      obs_a[ack_cnt] <= '{bus.ack, bus.rdata, bus.timeout, cyc};
      ack_cnt        <= ack_cnt + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic set_req(input int r, input logic io_v, input logic rw_v,
                         input logic s0, input logic s12, input logic [15:0] wd);
    bus.io[r]   = io_v;
    bus.rw[r]   = rw_v;
    bus.sa0[r]  = s0;
    bus.sa12[r] = s12;
    if (r == 0) bus.wdata0 = wd;
    else        bus.wdata1 = wd;
  endtask

  task automatic expect_txn(input string tag, input logic [1:0] a, input logic [15:0] rd,
                            input logic crd, input logic tmo, input int lat);
    exp_q.push_back('{tag, a, rd, crd, tmo, lat, cyc});
  endtask

  task automatic drain();
    exp_t e;
    while (n_done < ack_cnt) begin
      if (exp_q.size() == 0) begin
        chk_val("unexpected_ack", 32'(obs_a[n_done].ack), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk_val({e.tag, "_ack"}, 32'(obs_a[n_done].ack), 32'(e.ack));
        chk_val({e.tag, "_timeout"}, 32'(obs_a[n_done].tmo), 32'(e.tmo));
        if (e.chk_rd) chk_val({e.tag, "_rdata"}, 32'(obs_a[n_done].rdata), 32'(e.rdata));
        if (e.lat >= 0) chk_val({e.tag, "_latency"}, 32'(obs_a[n_done].cyc - e.t0), 32'(e.lat));
      end
      n_done++;
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_cnt < target && n < budget) begin
      @(posedge mclk);
      #1;
      n++;
    end
    if (ack_cnt < target) chk_val("ack_wait", 32'(ack_cnt), 32'(target));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int found;
    reset = 1'b0;
    bus.req = 2'b00; bus.io = 2'b00; bus.rw = 2'b00; bus.sa0 = 2'b00; bus.sa12 = 2'b00;
    bus.wdata0 = 16'h0; bus.wdata1 = 16'h0; bus.DG_IN = 16'h0;
    tick(3);

    // Reset state
    chk_val("rst_bale", 32'(bus.BALE), 32'h1);
    chk_val("rst_strobes", 32'({bus.MEMW, bus.MEMR, bus.IOW, bus.IOR}), 32'hF);
    chk_val("rst_sa", 32'({bus.SA12, bus.SA0}), 32'h3);
    chk_val("rst_dg_oe", 32'(bus.DG_OE), 32'h0);
    chk_val("rst_dg_out", 32'(bus.DG_OUT), 32'h0);
    chk_val("rst_ack", 32'(bus.ack), 32'h0);
    chk_val("rst_rdata", 32'(bus.rdata), 32'h0);
    chk_val("rst_timeout", 32'(bus.timeout), 32'h0);
    chk_val("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    tick(2);

    // Requester 0 IO read
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    bus.DG_IN = 16'h1234;
    stretch_n = 0;
    expect_txn("io_rd0", 2'b01, 16'h1234, 1'b1, 1'b0, 8);
    bus.req = 2'b01;
    wait_acks(1, 40);
    bus.req = 2'b00;
    chk_val("io_rd0_bale_len", 32'(last_bale_len), 32'd6);
    chk_val("io_rd0_strobe_id", 32'(last_strb_id), 32'd0);
    chk_val("io_rd0_strobe_len", 32'(last_strb_len), 32'd3);
    chk_val("io_rd0_sa", 32'(rec_sa), 32'h1);
    tick(4);

    // Requester 1 memory write with 4 WAIT-stretch cycles
    set_req(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA55A);
    stretch_n = 4;
    expect_txn("mem_wr1", 2'b10, 16'h0, 1'b0, 1'b0, 12);
    bus.req = 2'b10;
    wait_acks(2, 60);
    bus.req = 2'b00;
    chk_val("mem_wr1_strobe_id", 32'(last_strb_id), 32'd3);
    chk_val("mem_wr1_strobe_len", 32'(last_strb_len), 32'd7);
    chk_val("mem_wr1_bale_len", 32'(last_bale_len), 32'd10);
    chk_val("mem_wr1_oe_len", 32'(last_oe_len), 32'd10);
    chk_val("mem_wr1_dg_out", 32'(rec_dg_out), 32'hA55A);
    stretch_n = 0;
    tick(4);

    // Continuous contention: grants alternate, 10 cycles apart
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111);
    set_req(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
    expect_txn("rr_a0", 2'b01, 16'h0, 1'b0, 1'b0, -1);
    expect_txn("rr_a1", 2'b10, 16'h0, 1'b0, 1'b0, -1);
    expect_txn("rr_b0", 2'b01, 16'h0, 1'b0, 1'b0, -1);
    expect_txn("rr_b1", 2'b10, 16'h0, 1'b0, 1'b0, -1);
    bus.req = 2'b11;
    for (int i = 1; i <= 4; i++) wait_acks(2 + i, 40);
    bus.req = 2'b00;
    for (int i = 3; i <= 5; i++) chk_val("rr_gap", 32'(obs_a[i].cyc - obs_a[i-1].cyc), 32'd10);
    chk_val("rr_strobe_overlap", 32'(multi_seen), 32'h0);
    tick(4);

    // Memory read with WAIT stuck low: forced end after 8 stretch cycles
    set_req(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    bus.DG_IN = 16'h5A5A;
    stretch_n = 1000;
    expect_txn("tmo_rd", 2'b01, 16'hFFFF, 1'b1, 1'b1, 16);
    bus.req = 2'b01;
    wait_acks(7, 60);
    bus.req = 2'b00;
    tick(1);
    chk_val("tmo_next_timeout", 32'(tmo_next), 32'h0);
    chk_val("tmo_next_ack", 32'(ack_next), 32'h0);
    chk_val("tmo_strobe_id", 32'(last_strb_id), 32'd2);
    chk_val("tmo_strobe_len", 32'(last_strb_len), 32'd11);
    stretch_n = 0;
    tick(4);

    // Reset pulled during the strobe phase of a write
    set_req(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    bus.req = 2'b10;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.IOW == 1'b0) found = 1;
    end
    chk_val("rst_mid_iow_seen", 32'(found), 32'd1);
    chk_val("rst_mid_busy_before", 32'(bus.busy), 32'h1);
    chk_val("rst_mid_dg_oe_before", 32'(bus.DG_OE), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk_val("rst_mid_strobes", 32'({bus.MEMW, bus.MEMR, bus.IOW, bus.IOR}), 32'hF);
    chk_val("rst_mid_bale", 32'(bus.BALE), 32'h1);
    chk_val("rst_mid_dg_oe", 32'(bus.DG_OE), 32'h0);
    chk_val("rst_mid_busy", 32'(bus.busy), 32'h0);
    tick(2);
    bus.req = 2'b00;
    reset = 1'b1;
    tick(12);
    chk_val("rst_mid_no_ack", 32'(ack_cnt), 32'd7);
    chk_val("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    // First contention after reset goes to requester 0
    set_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    set_req(1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    bus.DG_IN = 16'hC3C3;
    expect_txn("post_rst0", 2'b01, 16'hC3C3, 1'b1, 1'b0, 8);
    expect_txn("post_rst1", 2'b10, 16'hC3C3, 1'b1, 1'b0, -1);
    bus.req = 2'b11;
    wait_acks(8, 40);
    bus.req = 2'b10;
    wait_acks(9, 40);
    bus.req = 2'b00;
    tick(4);

    // Requester 0 holds req through RECOVER: one extra cycle, latching updated address
    set_req(0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0);
    bus.DG_IN = 16'h0F0F;
    expect_txn("hold_a", 2'b01, 16'h0F0F, 1'b1, 1'b0, 8);
    expect_txn("hold_b", 2'b01, 16'h0F0F, 1'b1, 1'b0, -1);
    bus.req = 2'b01;
    wait_acks(10, 40);
    chk_val("hold_a_sa", 32'(rec_sa), 32'h2);
    bus.sa0[0] = 1'b1;
    bus.sa12[0] = 1'b0;
    tick(3);
    bus.req = 2'b00;
    bus.sa0[0] = 1'b0;
    bus.sa12[0] = 1'b1;
    tick(1);
    chk_val("hold_b_sa_pins", 32'({bus.SA12, bus.SA0}), 32'h1);
    wait_acks(11, 40);
    chk_val("hold_b_sa_latched", 32'(rec_sa), 32'h1);
    tick(30);
    chk_val("hold_one_new_cycle", 32'(ack_cnt), 32'd11);
    chk_val("hold_queue", 32'(exp_q.size()), 32'd0);
    chk_val("strobe_overlap", 32'(multi_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
